// File: rtl/hack_mem_pkg.sv
// Shared definitions for the RAM64 loader slice: default widths, FSM state
// encoding and a small helper for clamping transfer lengths to the memory depth.
package hack_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 7;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

    // Transfers longer than the memory would rewrite locations; clamp to one full pass.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] depth_c;
        depth_c = CNT_W'(DEPTH);
        return (c > depth_c) ? depth_c : c;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Address counter that loads a base, increments with natural modulo-2**WIDTH
// wrap, or holds. Used as the loader's current write address.
module wrap_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value
);

    // Load has priority over increment; the wrap 2**WIDTH-1 -> 0 falls out of the adder width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ram64_stream_loader.sv
// Stream-to-RAM64 preload stage: writes valid/ready stream words to consecutive
// RAM64 addresses from a programmed base, wrapping mod 64.
// Optional read-back check of every word is built when LOADER_VERIFY_EN is defined.
module ram64_stream_loader #(
    parameter int DATA_W = hack_mem_pkg::DATA_W,
    parameter int ADDR_W = hack_mem_pkg::ADDR_W,
    parameter int CNT_W  = hack_mem_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_done,
    output logic              err
);

    import hack_mem_pkg::*;

    loader_state_t     state;
    loader_state_t     next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  count_sat;
    logic              start_accept;
    logic              word_accept;
    logic              addr_load;

    assign count_sat    = sat_count(count);
    assign start_accept = (state == IDLE) && start;
    assign word_accept  = (state == WRITE) && s_valid;
    assign addr_load    = start_accept && (count_sat != '0);
    assign ram_in       = s_data;
    assign busy         = (state == WRITE) || (state == VERIFY);
    assign done         = (state == DONE);

    wrap_counter #(
        .WIDTH (ADDR_W)
    ) u_addr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (addr_load),
        .inc        (word_accept),
        .load_value (base_addr),
        .value      (cur_addr)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Remaining-word and completed-word counters, restarted by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining  <= '0;
            words_done <= '0;
        end else if (start_accept) begin
            remaining  <= count_sat;
            words_done <= '0;
        end else if (word_accept) begin
            remaining  <= remaining - CNT_W'(1);
            words_done <= words_done + CNT_W'(1);
        end
    end

`ifdef LOADER_VERIFY_EN
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // Keep a copy of the accepted word and flag any read-back mismatch until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (word_accept) begin
                data_q <= s_data;
            end
            if (start_accept) begin
                err_q <= 1'b0;
            end else if ((state == VERIFY) && (ram_out != data_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_ram_out;

    assign unused_ram_out = ^ram_out;
    assign err            = 1'b0;
`endif

    // Next state plus handshake and RAM control; the write happens on the accepting edge.
    always_comb begin
        next_state  = state;
        s_ready     = 1'b0;
        ram_load    = 1'b0;
        ram_address = cur_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (count_sat != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                s_ready  = 1'b1;
                ram_load = s_valid && rst_n;
                if (s_valid) begin
`ifdef LOADER_VERIFY_EN
                    next_state = VERIFY;
`else
                    next_state = (remaining == CNT_W'(1)) ? DONE : WRITE;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            VERIFY: begin
                ram_address = cur_addr - ADDR_W'(1);
                next_state  = (remaining == '0) ? DONE : WRITE;
            end
`endif
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram64_stream_loader.sv
// Directed bench for ram64_stream_loader with a behavioural RAM64 as the sink.
// Expected timing follows LOADER_VERIFY_EN when the bench is built with it.
module tb_ram64_stream_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  count;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [5:0]  ram_address;
    logic [15:0] ram_out;
    logic        busy;
    logic        done;
    logic [6:0]  words_done;
    logic        err;

    logic [15:0] mem [0:63];
    logic        block_load;
    int          write_cnt;
    int          checks;
    int          errors;
    int          wc_snap;

    ram64_stream_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_out     (ram_out),
        .busy        (busy),
        .done        (done),
        .words_done  (words_done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM64 model: synchronous write, combinational read; block_load suppresses a write.
    always @(posedge clk) begin
        if (ram_load && !block_load) mem[ram_address] <= ram_in;
        if (ram_load) write_cnt <= write_cnt + 1;
    end
    assign ram_out = mem[ram_address];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] b, input logic [6:0] c);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic [5:0] a);
        bit sent;
        sent    = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int k = 0; k < 8 && !sent; k++) begin
            @(negedge clk);
            if (s_ready) begin
                checkOutput("wr_addr", 32'(ram_address), 32'(a));
                checkOutput("wr_load", 32'(ram_load), 32'd1);
                sent = 1'b1;
            end
            tick();
        end
        s_valid = 1'b0;
        if (!sent) checkOutput("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input logic [6:0] exp_words, input logic exp_err);
`ifdef LOADER_VERIFY_EN
        checkOutput("verify_ready", 32'(s_ready), 32'd0);
        tick();
`endif
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_words", 32'(words_done), 32'(exp_words));
        checkOutput("done_err", 32'(err), 32'(exp_err));
        tick();
        checkOutput("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        write_cnt  = 0;
        block_load = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        count      = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'hE000 + 16'(i);
        tick();
        tick();

        // Reset state
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_words", 32'(words_done), 32'd0);
        checkOutput("rst_addr", 32'(ram_address), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: three back-to-back words from base 10
        applyStimulus(6'd10, 7'd3);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        send_word(16'h1111, 6'd10);
        send_word(16'h2222, 6'd11);
        send_word(16'h3333, 6'd12);
        wait_done(7'd3, 1'b0);
        checkOutput("t1_hold_addr", 32'(ram_address), 32'd13);
        checkOutput("t1_mem10", 32'(mem[10]), 32'h1111);
        checkOutput("t1_mem11", 32'(mem[11]), 32'h2222);
        checkOutput("t1_mem12", 32'(mem[12]), 32'h3333);

        // Test 2: wrap from 63 to 0
        applyStimulus(6'd62, 7'd4);
        send_word(16'h00A0, 6'd62);
        send_word(16'h00A1, 6'd63);
        send_word(16'h00A2, 6'd0);
        send_word(16'h00A3, 6'd1);
        wait_done(7'd4, 1'b0);
        checkOutput("t2_mem62", 32'(mem[62]), 32'h00A0);
        checkOutput("t2_mem63", 32'(mem[63]), 32'h00A1);
        checkOutput("t2_mem0", 32'(mem[0]), 32'h00A2);
        checkOutput("t2_mem1", 32'(mem[1]), 32'h00A3);
        checkOutput("t2_mem2", 32'(mem[2]), 32'hE002);

        // Test 3: zero-length transfer
        wc_snap = write_cnt;
        applyStimulus(6'd5, 7'd0);
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        checkOutput("t3_words", 32'(words_done), 32'd0);
        tick();
        checkOutput("t3_done_clear", 32'(done), 32'd0);
        checkOutput("t3_addr", 32'(ram_address), 32'd2);
        checkOutput("t3_no_write", 32'(write_cnt), 32'(wc_snap));

        // Test 4: stalls between words
        wc_snap = write_cnt;
        applyStimulus(6'd0, 7'd5);
        for (int i = 0; i < 5; i++) begin
            send_word(16'h4000 + 16'(i), 6'(i));
            if (i == 0 || i == 3) begin
                tick();
                tick();
                checkOutput("t4_stall_busy", 32'(busy), 32'd1);
            end
        end
        wait_done(7'd5, 1'b0);
        checkOutput("t4_writes", 32'(write_cnt - wc_snap), 32'd5);
        checkOutput("t4_mem0", 32'(mem[0]), 32'h4000);
        checkOutput("t4_mem4", 32'(mem[4]), 32'h4004);

        // Test 5: start ignored while busy, then reset mid-transfer
        applyStimulus(6'd20, 7'd4);
        send_word(16'h5550, 6'd20);
        send_word(16'h5551, 6'd21);
        start     = 1'b1;
        base_addr = 6'd40;
        count     = 7'd1;
        tick();
        start = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd1);
        checkOutput("t5_words", 32'(words_done), 32'd2);
        checkOutput("t5_addr", 32'(ram_address), 32'd22);
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        rst_n   = 1'b0;
        #1;
        checkOutput("t5_load_gated", 32'(ram_load), 32'd0);
        wc_snap = write_cnt;
        tick();
        s_valid = 1'b0;
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        checkOutput("t5_rst_words", 32'(words_done), 32'd0);
        checkOutput("t5_rst_addr", 32'(ram_address), 32'd0);
        checkOutput("t5_rst_err", 32'(err), 32'd0);
        checkOutput("t5_no_write", 32'(write_cnt), 32'(wc_snap));
        checkOutput("t5_mem21", 32'(mem[21]), 32'h5551);
        checkOutput("t5_mem22", 32'(mem[22]), 32'hE016);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t5_no_done", 32'(done), 32'd0);
        end

`ifdef LOADER_VERIFY_EN
        // Test 6: suppressed write is caught by the read-back check
        applyStimulus(6'd30, 7'd3);
        send_word(16'h00C0, 6'd30);
        block_load = 1'b1;
        send_word(16'h00C1, 6'd31);
        block_load = 1'b0;
        checkOutput("t6_verify_ready", 32'(s_ready), 32'd0);
        checkOutput("t6_verify_addr", 32'(ram_address), 32'd31);
        checkOutput("t6_err_before", 32'(err), 32'd0);
        tick();
        checkOutput("t6_err_set", 32'(err), 32'd1);
        send_word(16'h00C2, 6'd32);
        wait_done(7'd3, 1'b1);
        checkOutput("t6_err_sticky", 32'(err), 32'd1);
        applyStimulus(6'd50, 7'd1);
        checkOutput("t6_err_clear", 32'(err), 32'd0);
        send_word(16'h00D0, 6'd50);
        wait_done(7'd1, 1'b0);
`endif

        // Test 7: oversize count saturates to a full pass from base 5
        applyStimulus(6'd5, 7'd100);
        for (int i = 0; i < 64; i++) send_word(16'h6000 + 16'(i), 6'(5 + i));
        wait_done(7'd64, 1'b0);
        checkOutput("t7_mem5", 32'(mem[5]), 32'h6000);
        checkOutput("t7_mem4", 32'(mem[4]), 32'h603F);
        checkOutput("t7_addr", 32'(ram_address), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
